// File: rtl/sec_ctrl.sv
// Seconds counter and mode controller for a digital clock: debounced MODE/SET
// buttons, BCD seconds, minute carry, manual set pulses and blink request.
module sec_ctrl #(
  parameter int DIV = 50000000,
  parameter int DEB = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_MODE,
  input  logic       BTN_SET,
  output logic [3:0] SL,
  output logic [2:0] SH,
  output logic       MINEN,
  output logic       MININC,
  output logic       HOURINC,
  output logic [1:0] MODE,
  output logic       BLINK
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SETHOUR = 2'b01,
    SETMIN  = 2'b10,
    ILLEGAL = 2'b11
  } mode_t;

  localparam logic [19:0] DEB_M1 = 20'(DEB - 1);
  localparam logic [25:0] PC_MAX = 26'(DIV - 1);
  localparam logic [25:0] PC_HALF = 26'(DIV / 2);

  // Bit 0 carries the MODE button, bit 1 the SET button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync_p0, sync_p1;
  logic [1:0]       lvl_p2, lvl_p3;
  logic [1:0][19:0] deb_cnt;
  logic [1:0]       press_p4;
  logic             press_mode, press_set;

  mode_t       state, state_nxt;
  logic        clr_sec, clr_pc;
  logic [25:0] pc;
  logic        tick;

  assign btn_raw    = {BTN_SET, BTN_MODE};
  assign press_mode = press_p4[0];
  assign press_set  = press_p4[1];

  // Synchronizer -> debounced level -> one-cycle press pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      lvl_p2   <= '0;
      lvl_p3   <= '0;
      deb_cnt  <= '0;
      press_p4 <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      lvl_p3   <= lvl_p2;
      press_p4 <= lvl_p2 & ~lvl_p3;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != lvl_p2[i]) begin
          if (deb_cnt[i] == DEB_M1) begin
            lvl_p2[i]  <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 20'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_sec   = 1'b0;
    clr_pc    = 1'b0;
    if (state == ILLEGAL) begin
      state_nxt = NORMAL;
    end else if (press_mode) begin
      case (state)
        NORMAL: begin
          state_nxt = SETHOUR;
          clr_sec   = 1'b1;
        end
        SETHOUR: state_nxt = SETMIN;
        SETMIN: begin
          state_nxt = NORMAL;
          clr_pc    = 1'b1;
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end

  assign tick = (pc == PC_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              pc <= '0;
    else if (clr_pc || tick) pc <= '0;
    else                  pc <= pc + 26'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SL <= '0;
      SH <= '0;
    end else if (clr_sec) begin
      SL <= '0;
      SH <= '0;
    end else if (state == NORMAL && tick) begin
      if (SL == 4'd9) begin
        SL <= '0;
        SH <= (SH == 3'd5) ? 3'd0 : SH + 3'd1;
      end else begin
        SL <= SL + 4'd1;
      end
    end
  end

  // A SET press coinciding with a MODE press is dropped.
  assign MINEN   = (state == NORMAL) && tick && (SH == 3'd5) && (SL == 4'd9);
  assign MININC  = press_set && !press_mode && (state == SETMIN);
  assign HOURINC = press_set && !press_mode && (state == SETHOUR);
  assign MODE    = state;
  assign BLINK   = (state != NORMAL) && (pc < PC_HALF);

endmodule

// File: tb/tb_sec_ctrl.sv
// Directed bench for sec_ctrl with DIV=10, DEB=4 and hand-computed expectations.
module tb_sec_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_MODE = 1'b0;
  logic       BTN_SET = 1'b0;
  logic [3:0] SL;
  logic [2:0] SH;
  logic       MINEN, MININC, HOURINC;
  logic [1:0] MODE;
  logic       BLINK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int minen_cnt = 0, mininc_cnt = 0, hourinc_cnt = 0, clash_cnt = 0;
  int base_minen, base_min, base_hour;
  int minen_j;

  always #5 CLK = ~CLK;

  sec_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_SET(BTN_SET),
    .SL(SL), .SH(SH), .MINEN(MINEN), .MININC(MININC), .HOURINC(HOURINC),
    .MODE(MODE), .BLINK(BLINK)
  );

  // Posedges since reset release; equals the prescaler while it is uncleared.
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (MINEN)   minen_cnt++;
      if (MININC)  mininc_cnt++;
      if (HOURINC) hourinc_cnt++;
      if ((MININC && HOURINC) || ((MININC || HOURINC) && MINEN)) clash_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int s);
    return 32'((s / 10) * 16 + (s % 10));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
  endtask

  task automatic press_mode_rel();
    BTN_MODE = 1'b1;
    step(8);
    BTN_MODE = 1'b0;
    step(8);
  endtask

  task automatic press_set_rel();
    BTN_SET = 1'b1;
    step(8);
    BTN_SET = 1'b0;
    step(8);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(3);
    chk("rst_secs", 32'({SH, SL}), 32'd0);
    chk("rst_mode", 32'(MODE), 32'd0);
    chk("rst_pulses", 32'({MINEN, MININC, HOURINC, BLINK}), 32'd0);
    RST = 1'b0;

    // Free-running seconds and minute carry
    minen_j = -1;
    base_minen = minen_cnt;
    for (int j = 0; j <= 600; j++) begin
      if (j > 0) step(1);
      chk("run_secs", 32'({SH, SL}), bcd((j / 10) % 60));
      if (MINEN) minen_j = j;
    end
    chk("minen_count", 32'(minen_cnt - base_minen), 32'd1);
    chk("minen_cycle", 32'(minen_j), 32'd599);
    chk("run_blink", 32'(BLINK), 32'd0);

    // Three MODE presses starting at 42 seconds
    do_reset();
    step(420);
    chk("secs_42", 32'({SH, SL}), bcd(42));
    BTN_MODE = 1'b1;
    step(7);
    chk("mode_before_edge", 32'(MODE), 32'd0);
    chk("secs_before_edge", 32'({SH, SL}), bcd(42));
    step(1);
    chk("mode_sethour", 32'(MODE), 32'd1);
    chk("secs_cleared", 32'({SH, SL}), 32'd0);
    base_minen = minen_cnt;
    BTN_MODE = 1'b0;
    step(8);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("blink_sethour", 32'(BLINK), 32'((cyc % 10) < 5));
      chk("frozen_sethour", 32'({SH, SL}), 32'd0);
    end
    BTN_MODE = 1'b1;
    step(8);
    chk("mode_setmin", 32'(MODE), 32'd2);
    BTN_MODE = 1'b0;
    step(8);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("blink_setmin", 32'(BLINK), 32'((cyc % 10) < 5));
      chk("frozen_setmin", 32'({SH, SL}), 32'd0);
    end
    BTN_MODE = 1'b1;
    step(8);
    chk("mode_normal", 32'(MODE), 32'd0);
    chk("minen_in_set", 32'(minen_cnt - base_minen), 32'd0);
    chk("blink_normal", 32'(BLINK), 32'd0);
    step(9);
    chk("full_second_hold", 32'({SH, SL}), 32'd0);
    step(1);
    chk("full_second_step", 32'({SH, SL}), bcd(1));
    BTN_MODE = 1'b0;
    step(8);

    // SET glitch and held press in SETMIN
    press_mode_rel();
    press_mode_rel();
    chk("mode_setmin2", 32'(MODE), 32'd2);
    base_min = mininc_cnt;
    base_hour = hourinc_cnt;
    BTN_SET = 1'b1;
    step(3);
    BTN_SET = 1'b0;
    step(12);
    chk("glitch_mininc", 32'(mininc_cnt - base_min), 32'd0);
    BTN_SET = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("mininc_timing", 32'(MININC), 32'(k == 7));
    end
    BTN_SET = 1'b0;
    step(8);
    chk("held_mininc", 32'(mininc_cnt - base_min), 32'd1);
    chk("held_hourinc", 32'(hourinc_cnt - base_hour), 32'd0);

    // MODE and SET together in SETHOUR
    press_mode_rel();
    press_mode_rel();
    chk("mode_sethour2", 32'(MODE), 32'd1);
    base_min = mininc_cnt;
    base_hour = hourinc_cnt;
    BTN_MODE = 1'b1;
    BTN_SET = 1'b1;
    step(8);
    chk("both_mode", 32'(MODE), 32'd2);
    BTN_MODE = 1'b0;
    BTN_SET = 1'b0;
    step(8);
    chk("both_hourinc", 32'(hourinc_cnt - base_hour), 32'd0);
    chk("both_mininc", 32'(mininc_cnt - base_min), 32'd0);

    // Two hour increments, then one minute increment
    do_reset();
    press_mode_rel();
    base_min = mininc_cnt;
    base_hour = hourinc_cnt;
    press_set_rel();
    press_set_rel();
    press_mode_rel();
    chk("seq_mode", 32'(MODE), 32'd2);
    chk("seq_hour2", 32'(hourinc_cnt - base_hour), 32'd2);
    chk("seq_min0", 32'(mininc_cnt - base_min), 32'd0);
    press_set_rel();
    chk("seq_min1", 32'(mininc_cnt - base_min), 32'd1);
    chk("seq_hour_final", 32'(hourinc_cnt - base_hour), 32'd2);

    // Asynchronous reset at 37 seconds, then mid-set with a held button
    do_reset();
    step(370);
    chk("secs_37", 32'({SH, SL}), bcd(37));
    RST = 1'b1;
    #1;
    chk("async_rst_secs", 32'({SH, SL}), 32'd0);
    step(2);
    RST = 1'b0;
    press_mode_rel();
    press_mode_rel();
    chk("mode_setmin3", 32'(MODE), 32'd2);
    BTN_MODE = 1'b1;
    step(3);
    RST = 1'b1;
    #1;
    chk("rst_set_mode", 32'(MODE), 32'd0);
    chk("rst_set_out", 32'({SH, SL, MINEN, MININC, HOURINC, BLINK}), 32'd0);
    step(2);
    chk("rst_hold_mode", 32'(MODE), 32'd0);
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("held_through_rst", 32'(MODE), 32'((k >= 8) ? 1 : 0));
    end
    BTN_MODE = 1'b0;
    step(8);

    chk("no_clash", 32'(clash_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
